uart_reg_ctrl: RTL and testbench



---
 rtl/uart_reg_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_reg_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: host-facing register block for the UART peripheral.
//   Owns the control and data registers, sequences the transmitter when
//   software sets SEND, and captures received bytes with status flags.
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   wr_i, reg_sel_i    host write strobe and register select (0 = ctrl, 1 = data)
//   wdata_i            host write data
//   rd_data_o          combinational read mux of the register chosen by reg_sel_i
//   tx_start_o         one-cycle start pulse to the transmitter
//   tx_data_o          byte on the line, held from one start to the next
//   tx_rdy_i           transmitter idle/ready
//   rx_done_i          one-cycle pulse when the receiver has a byte on rx_data_i
//   irq_o              registered interrupt (only with UART_REG_CTRL_IRQ_EN)
//
// Control register: bit0 SEND, bit1 RX_NEW, bit2 OVERRUN, bit3 TX_ERR,
// bit4 TX_DONE (only with UART_REG_CTRL_IRQ_EN). SEND can only be set by
// software; flags 1..4 can only be cleared by software (writing 0), and a
// hardware set in the same cycle always beats a software clear.
//
// Optional feature macro: UART_REG_CTRL_IRQ_EN.

module uart_reg_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_i,
  input  logic          reg_sel_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rd_data_o,
  output logic          tx_start_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_rdy_i,
  input  logic          rx_done_i,
  input  logic [7:0]    rx_data_i
`ifdef UART_REG_CTRL_IRQ_EN
  ,
  output logic          irq_o
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  logic       send;
  logic       rx_new;
  logic       overrun;
  logic       tx_err;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;

  logic ctrl_wr;
  logic data_wr;
  logic hw_clr_send;
  logic hw_set_err;
  logic load_tx;

`ifdef UART_REG_CTRL_IRQ_EN
  logic tx_done;
  logic hw_set_done;
`endif

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  assign ctrl_wr = wr_i & ~reg_sel_i;
  assign data_wr = wr_i & reg_sel_i;

  // ---------------------------------------------------------------------------
  // Transmit sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hw_clr_send = 1'b0;
    hw_set_err  = 1'b0;
    load_tx     = 1'b0;
`ifdef UART_REG_CTRL_IRQ_EN
    hw_set_done = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (send && tx_rdy_i) begin
          state_nxt = START;
          load_tx   = 1'b1;
        end
      end
      START: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A drop of tx_rdy_i takes priority over the timeout on the last cycle.
        if (!tx_rdy_i) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt   = IDLE;
          hw_set_err  = 1'b1;
          hw_clr_send = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_rdy_i) begin
          state_nxt   = IDLE;
          hw_clr_send = 1'b1;
`ifdef UART_REG_CTRL_IRQ_EN
          hw_set_done = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counts cycles spent in WAIT_BUSY; zero everywhere else.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (state != WAIT_BUSY) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tx_start_o = (state == START);

  // The byte is captured on entry to START so it is already valid alongside
  // the start pulse, and later data writes cannot disturb the line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_data_o <= '0;
    end else if (load_tx) begin
      tx_data_o <= tx_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      send    <= 1'b0;
      rx_new  <= 1'b0;
      overrun <= 1'b0;
      tx_err  <= 1'b0;
      tx_byte <= '0;
      rx_byte <= '0;
    end else begin
      // Host set of SEND wins over the sequencer clearing it.
      if (ctrl_wr && wdata_i[0]) begin
        send <= 1'b1;
      end else if (hw_clr_send) begin
        send <= 1'b0;
      end

      if (rx_done_i) begin
        rx_new <= 1'b1;
      end else if (ctrl_wr && !wdata_i[1]) begin
        rx_new <= 1'b0;
      end

      // Overrun looks at RX_NEW as it stood before this cycle's write.
      if (rx_done_i && rx_new) begin
        overrun <= 1'b1;
      end else if (ctrl_wr && !wdata_i[2]) begin
        overrun <= 1'b0;
      end

      if (hw_set_err) begin
        tx_err <= 1'b1;
      end else if (ctrl_wr && !wdata_i[3]) begin
        tx_err <= 1'b0;
      end

      if (rx_done_i) begin
        rx_byte <= rx_data_i;
      end

      if (data_wr) begin
        tx_byte <= wdata_i[7:0];
      end
    end
  end

`ifdef UART_REG_CTRL_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_done <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      if (hw_set_done) begin
        tx_done <= 1'b1;
      end else if (ctrl_wr && !wdata_i[4]) begin
        tx_done <= 1'b0;
      end
      irq_o <= rx_new | overrun | tx_err | tx_done;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [4:0] ctrl_val;

`ifdef UART_REG_CTRL_IRQ_EN
  assign ctrl_val = {tx_done, tx_err, overrun, rx_new, send};
`else
  assign ctrl_val = {1'b0, tx_err, overrun, rx_new, send};
`endif

  always_comb begin
    rd_data_o = '0;
    if (reg_sel_i) begin
      rd_data_o[7:0] = rx_byte;
    end else begin
      rd_data_o[4:0] = ctrl_val;
    end
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Bench for uart_reg_ctrl: directed host/TX/RX stimulus, a behavioural
// reference checked every cycle, and literal expectations at key points.

module tb_uart_reg_ctrl;

  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
`ifdef UART_REG_CTRL_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr;
  logic          reg_sel;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rd_data;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_rdy;
  logic          rx_done;
  logic [7:0]    rx_data;
`ifdef UART_REG_CTRL_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  uart_reg_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wr_i       (wr),
    .reg_sel_i  (reg_sel),
    .wdata_i    (wdata),
    .rd_data_o  (rd_data),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .tx_rdy_i   (tx_rdy),
    .rx_done_i  (rx_done),
    .rx_data_i  (rx_data)
`ifdef UART_REG_CTRL_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_starts = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. A transfer is: one pulse cycle, then a watch period.
  // While the line has not yet gone busy, TIMEOUT ready-high cycles abort
  // with an error; once it has gone busy, the first ready-high cycle ends it.
  // ---------------------------------------------------------------------------
  logic       m_send, m_rxnew, m_ovr, m_err, m_done, m_irq;
  logic       m_pulse, m_watch, m_dropped;
  int         m_age;
  logic [7:0] m_txbyte, m_rxbyte, m_txdata;

  always @(posedge clk or negedge rst_n) begin : model
    logic clr_send, set_err, set_done, cw, dw;
    if (!rst_n) begin
      m_send <= 0; m_rxnew <= 0; m_ovr <= 0; m_err <= 0; m_done <= 0; m_irq <= 0;
      m_pulse <= 0; m_watch <= 0; m_dropped <= 0; m_age <= 0;
      m_txbyte <= 0; m_rxbyte <= 0; m_txdata <= 0;
    end else begin
      clr_send = 0; set_err = 0; set_done = 0;
      cw = wr && !reg_sel;
      dw = wr && reg_sel;
      m_pulse <= 1'b0;
      if (m_pulse) begin
        m_watch <= 1'b1; m_dropped <= 1'b0; m_age <= 0;
      end else if (m_watch) begin
        if (!m_dropped) begin
          if (!tx_rdy) m_dropped <= 1'b1;
          else if (m_age + 1 == TIMEOUT) begin
            set_err = 1; clr_send = 1; m_watch <= 1'b0;
          end else m_age <= m_age + 1;
        end else if (tx_rdy) begin
          clr_send = 1; set_done = IRQ; m_watch <= 1'b0;
        end
      end else if (m_send && tx_rdy) begin
        m_pulse <= 1'b1; m_txdata <= m_txbyte;
      end

      if (cw && wdata[0]) m_send <= 1'b1; else if (clr_send) m_send <= 1'b0;
      if (rx_done) m_rxnew <= 1'b1; else if (cw && !wdata[1]) m_rxnew <= 1'b0;
      if (rx_done && m_rxnew) m_ovr <= 1'b1; else if (cw && !wdata[2]) m_ovr <= 1'b0;
      if (set_err) m_err <= 1'b1; else if (cw && !wdata[3]) m_err <= 1'b0;
      if (set_done) m_done <= 1'b1; else if (cw && !wdata[4]) m_done <= 1'b0;
      if (rx_done) m_rxbyte <= rx_data;
      if (dw) m_txbyte <= wdata[7:0];
      m_irq <= m_rxnew | m_ovr | m_err | m_done;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_start", {31'b0, tx_start}, {31'b0, m_pulse});
      chk("tx_data", {24'b0, tx_data}, {24'b0, m_txdata});
      if (reg_sel) chk("rd_data", rd_data, {24'b0, m_rxbyte});
      else chk("rd_ctrl", rd_data, {27'b0, m_done, m_err, m_ovr, m_rxnew, m_send});
`ifdef UART_REG_CTRL_IRQ_EN
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
      if (tx_start) n_starts++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic sel, input logic [DW-1:0] d);
    wr = 1'b1; reg_sel = sel; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic peek(input logic sel, input string name,
                      input logic [DW-1:0] exp, input logic [DW-1:0] mask);
    reg_sel = sel;
    @(negedge clk);
    chk(name, rd_data & mask, exp);
  endtask

  task automatic peek_tx(input string name, input logic st, input logic [7:0] d);
    @(negedge clk);
    chk({name, "_start"}, {31'b0, tx_start}, {31'b0, st});
    chk({name, "_data"}, {24'b0, tx_data}, {24'b0, d});
  endtask

  int s0;

  initial begin
    rst_n = 0; wr = 0; reg_sel = 0; wdata = '0;
    tx_rdy = 0; rx_done = 0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1; chk_en = 1'b1;

    // Dirty the registers, then reset asynchronously.
    wr_reg(0, 32'h1);
    rx_done = 1; rx_data = 8'h11; tick(); rx_done = 0;
    peek(0, "dirty_ctrl", 32'h3, 32'hF);
    tick(); rst_n = 0;
    peek(0, "rst_ctrl", 32'h0, '1);
    tick(); peek(1, "rst_data", 32'h0, '1);
    tick(); peek_tx("rst_tx", 1'b0, 8'h00);
    tick(); rst_n = 1;

    // Basic send: start pulse two cycles after the SEND write.
    tx_rdy = 1;
    wr_reg(1, 32'h5A);
    wr_reg(0, 32'h1);
    peek_tx("send_n1", 1'b0, 8'h00);
    tick(); peek_tx("send_n2", 1'b1, 8'h5A);
    tick(); tx_rdy = 0;
    wr_reg(1, 32'hFF);
    repeat (8) tick();
    tx_rdy = 1;
    peek_tx("hold_5a", 1'b0, 8'h5A);
    tick(); tick();
    peek(0, "send_clr", 32'h0, 32'h1);

    // Next SEND transmits the byte written mid-transfer.
    tick(); wr_reg(0, 32'h1);
    tick(); peek_tx("send_ff", 1'b1, 8'hFF);
    tick(); tx_rdy = 0;
    repeat (3) tick();
    tx_rdy = 1;
    repeat (3) tick();

    // Two receptions without a clear: overwrite plus overrun.
    rx_done = 1; rx_data = 8'h3C; tick();
    rx_data = 8'h7E; tick(); rx_done = 0;
    peek(1, "rx_data", 32'h7E, '1);
    tick(); peek(0, "rx_ctrl", 32'h6, 32'hF);
    tick(); wr_reg(0, 32'h0);
    peek(0, "rx_clr", 32'h0, 32'hF);

    // Transmitter never goes busy: timeout after TIMEOUT cycles.
    tick(); wr_reg(0, 32'h1);
    tick(); peek_tx("to_start", 1'b1, 8'hFF);
    tick(); s0 = n_starts;
    repeat (15) tick();
    peek(0, "to_before", 32'h0, 32'h8);
    tick(); peek(0, "to_err", 32'h8, 32'hF);
    repeat (6) tick();
    chk("to_no_restart", n_starts - s0, 0);
    wr_reg(0, 32'h0);

    // Host SEND write in the very cycle the sequencer clears SEND.
    wr_reg(0, 32'h1);
    tick();                 // START
    tick(); tx_rdy = 0;     // WAIT_BUSY, line goes busy
    tick(); tx_rdy = 1;     // WAIT_DONE, ready returns
    wr_reg(0, 32'h1);
    peek(0, "coll_send", 32'h1, 32'h1);
    tick(); peek_tx("coll_start", 1'b1, 8'hFF);
    tick(); tx_rdy = 0;
    tick(); tick(); tx_rdy = 1;
    repeat (3) tick();

    // Reception coincident with a software clear of RX_NEW.
    rx_done = 1; rx_data = 8'h21; tick();
    rx_data = 8'h42;
    wr_reg(0, 32'h0);
    rx_done = 0;
    peek(0, "rxc_ctrl", 32'h6, 32'hF);
    tick(); peek(1, "rxc_data", 32'h42, '1);
    tick(); wr_reg(0, 32'h0);
    peek(0, "rxc_clr", 32'h0, 32'hF);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
